// File: rtl/nabu_kbd_pkg.sv
// rtl/nabu_kbd_pkg.sv - shared constants and key-map types for the NABU keyboard front end
//
// Purpose: protocol bytes, modifier scancodes and the lookup-result struct
//          used by nabu_kbd_map and nabu_kbd.
// Ports:   none (package).
package nabu_kbd_pkg;

    localparam logic [7:0] NABU_WDT_BYTE  = 8'h95;
    localparam logic [7:0] NABU_SPC_PRESS = 8'hE0;
    localparam logic [7:0] NABU_SPC_REL   = 8'hF0;

    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    typedef enum logic [1:0] {
        KIND_NONE,
        KIND_ASCII,
        KIND_SPECIAL,
        KIND_MOD
    } kbd_kind_e;

    typedef struct packed {
        kbd_kind_e  kind;
        logic [7:0] ascii;
        logic [7:0] ascii_shift;
        logic [3:0] spc_idx;
    } kbd_map_t;

    function automatic kbd_map_t map_ascii(input logic [7:0] a, input logic [7:0] s);
        map_ascii = '{kind: KIND_ASCII, ascii: a, ascii_shift: s, spc_idx: 4'd0};
    endfunction

    function automatic kbd_map_t map_spc(input logic [3:0] idx);
        map_spc = '{kind: KIND_SPECIAL, ascii: 8'h00, ascii_shift: 8'h00, spc_idx: idx};
    endfunction

    function automatic kbd_map_t map_mod();
        map_mod = '{kind: KIND_MOD, ascii: 8'h00, ascii_shift: 8'h00, spc_idx: 4'd0};
    endfunction

endpackage

// File: rtl/nabu_kbd_map.sv
// rtl/nabu_kbd_map.sv - combinational set-2 scancode to NABU key classification (US layout)
//
// Purpose: classifies one scancode as modifier, printable (with unshifted and
//          shifted ASCII), special key (with NABU index) or unmapped.
// Ports:   ext_i      - scancode carried an E0 prefix
//          scancode_i - set-2 scancode
//          map_o      - lookup result
module nabu_kbd_map
    import nabu_kbd_pkg::*;
(
    input  logic       ext_i,
    input  logic [7:0] scancode_i,
    output kbd_map_t   map_o
);

    always_comb begin
        map_o = '{kind: KIND_NONE, ascii: 8'h00, ascii_shift: 8'h00, spc_idx: 4'd0};
        if (ext_i) begin
            case (scancode_i)
                8'h14: map_o = map_mod();
                8'h74: map_o = map_spc(4'd0);
                8'h6B: map_o = map_spc(4'd1);
                8'h75: map_o = map_spc(4'd2);
                8'h72: map_o = map_spc(4'd3);
                8'h7A: map_o = map_spc(4'd4);
                8'h7D: map_o = map_spc(4'd5);
                8'h69: map_o = map_spc(4'd6);
                8'h6C: map_o = map_spc(4'd7);
                default: ;
            endcase
        end else begin
            case (scancode_i)
                8'h12, 8'h59, 8'h14, 8'h58: map_o = map_mod();
                8'h05: map_o = map_spc(4'd8);
                8'h04: map_o = map_spc(4'd9);
                8'h0C: map_o = map_spc(4'd10);
                8'h1C: map_o = map_ascii("a", "A");
                8'h32: map_o = map_ascii("b", "B");
                8'h21: map_o = map_ascii("c", "C");
                8'h23: map_o = map_ascii("d", "D");
                8'h24: map_o = map_ascii("e", "E");
                8'h2B: map_o = map_ascii("f", "F");
                8'h34: map_o = map_ascii("g", "G");
                8'h33: map_o = map_ascii("h", "H");
                8'h43: map_o = map_ascii("i", "I");
                8'h3B: map_o = map_ascii("j", "J");
                8'h42: map_o = map_ascii("k", "K");
                8'h4B: map_o = map_ascii("l", "L");
                8'h3A: map_o = map_ascii("m", "M");
                8'h31: map_o = map_ascii("n", "N");
                8'h44: map_o = map_ascii("o", "O");
                8'h4D: map_o = map_ascii("p", "P");
                8'h15: map_o = map_ascii("q", "Q");
                8'h2D: map_o = map_ascii("r", "R");
                8'h1B: map_o = map_ascii("s", "S");
                8'h2C: map_o = map_ascii("t", "T");
                8'h3C: map_o = map_ascii("u", "U");
                8'h2A: map_o = map_ascii("v", "V");
                8'h1D: map_o = map_ascii("w", "W");
                8'h22: map_o = map_ascii("x", "X");
                8'h35: map_o = map_ascii("y", "Y");
                8'h1A: map_o = map_ascii("z", "Z");
                8'h16: map_o = map_ascii("1", "!");
                8'h1E: map_o = map_ascii("2", "@");
                8'h26: map_o = map_ascii("3", "#");
                8'h25: map_o = map_ascii("4", "$");
                8'h2E: map_o = map_ascii("5", "%");
                8'h36: map_o = map_ascii("6", "^");
                8'h3D: map_o = map_ascii("7", "&");
                8'h3E: map_o = map_ascii("8", "*");
                8'h46: map_o = map_ascii("9", "(");
                8'h45: map_o = map_ascii("0", ")");
                8'h4E: map_o = map_ascii("-", "_");
                8'h55: map_o = map_ascii("=", "+");
                8'h54: map_o = map_ascii("[", "{");
                8'h5B: map_o = map_ascii("]", "}");
                8'h5D: map_o = map_ascii("\\", "|");
                8'h4C: map_o = map_ascii(";", ":");
                8'h52: map_o = map_ascii("'", "\"");
                8'h0E: map_o = map_ascii(8'h60, 8'h7E);
                8'h41: map_o = map_ascii(",", "<");
                8'h49: map_o = map_ascii(".", ">");
                8'h4A: map_o = map_ascii("/", "?");
                8'h29: map_o = map_ascii(8'h20, 8'h20);
                8'h5A: map_o = map_ascii(8'h0D, 8'h0D);
                8'h66: map_o = map_ascii(8'h08, 8'h08);
                8'h0D: map_o = map_ascii(8'h09, 8'h09);
                8'h76: map_o = map_ascii(8'h1B, 8'h1B);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/nabu_kbd.sv
// rtl/nabu_kbd.sv - PS/2 event to NABU keyboard byte translator with output FIFO and watchdog
//
// Purpose: detects hps_io key events, tracks shift/ctrl/caps, translates keys to
//          NABU bytes, injects a periodic watchdog byte and queues bytes in a FWFT FIFO.
// Ports:   clk, reset           - system clock, synchronous active-high reset
//          ps2_key[10:0]        - {strobe toggle, press, ext, scancode}
//          out_valid/out_data   - FIFO head
//          out_ready            - downstream pops the head
//          drop                 - pulse when a key byte was lost to a full FIFO
//          caps_led             - caps-lock state
module nabu_kbd
    import nabu_kbd_pkg::*;
#(
    parameter int unsigned WDT_CYCLES = 160_000_000,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        drop,
    output logic        caps_led
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int WW = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
    localparam logic [WW-1:0] WDT_LAST = WW'(WDT_CYCLES - 1);
    localparam logic [AW:0]   DEPTH    = (AW + 1)'(FIFO_DEPTH);

    logic          strb_q;
    logic          shift_q, shift_d, ctrl_q, ctrl_d, caps_q, caps_d;
    logic          ev_valid_q, ev_valid_d;
    logic [7:0]    ev_byte_q, ev_byte_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic [WW-1:0] wdt_cnt_q;
    logic          wdt_pend_q;
    logic          drop_q;

    kbd_map_t key_map;
    logic [7:0] base;
    logic event_fire, press, is_letter;
    logic full, pop, accept, key_push, wdt_push, push, wdt_wrap;
    logic [7:0] push_byte;

    nabu_kbd_map u_map (
        .ext_i      (ps2_key[8]),
        .scancode_i (ps2_key[7:0]),
        .map_o      (key_map)
    );

    assign event_fire = ps2_key[10] != strb_q;
    assign press      = ps2_key[9];
    assign base       = key_map.ascii;
    assign is_letter  = (base >= 8'h61) && (base <= 8'h7A);

    // Translation uses the modifier state from before this event; modifier
    // events themselves never produce a byte so this ordering is safe.
    always_comb begin
        shift_d    = shift_q;
        ctrl_d     = ctrl_q;
        caps_d     = caps_q;
        ev_valid_d = 1'b0;
        ev_byte_d  = ev_byte_q;
        if (event_fire) begin
            case (key_map.kind)
                KIND_MOD: begin
                    if (ps2_key[7:0] == SC_LSHIFT || ps2_key[7:0] == SC_RSHIFT) shift_d = press;
                    else if (ps2_key[7:0] == SC_CTRL) ctrl_d = press;
                    else if (ps2_key[7:0] == SC_CAPS && press) caps_d = !caps_q;
                end
                KIND_ASCII: begin
                    if (press) begin
                        ev_valid_d = 1'b1;
                        if (ctrl_q && base >= 8'h40 && base <= 8'h7F) ev_byte_d = base & 8'h1F;
                        else if (is_letter) ev_byte_d = (shift_q ^ caps_q) ? base - 8'h20 : base;
                        else ev_byte_d = shift_q ? key_map.ascii_shift : base;
                    end
                end
                KIND_SPECIAL: begin
                    ev_valid_d = 1'b1;
                    ev_byte_d  = (press ? NABU_SPC_PRESS : NABU_SPC_REL) + {4'h0, key_map.spc_idx};
                end
                default: ;
            endcase
        end
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    // Key bytes own the write port; the watchdog byte only takes idle slots.
    assign out_valid = count_q != '0;
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign full      = count_q == DEPTH;
    assign pop       = out_valid && out_ready;
    assign accept    = !full || pop;
    assign key_push  = ev_valid_q && accept;
    assign wdt_push  = wdt_pend_q && !ev_valid_q && accept;
    assign push      = key_push || wdt_push;
    assign push_byte = ev_valid_q ? ev_byte_q : NABU_WDT_BYTE;
    assign wdt_wrap  = wdt_cnt_q == WDT_LAST;
    assign drop      = drop_q;
    assign caps_led  = caps_q;

    always_ff @(posedge clk) begin
        if (push && !reset) mem_q[wr_ptr_q] <= push_byte;
    end

    always_ff @(posedge clk) begin
        strb_q <= ps2_key[10];
        if (reset) begin
            shift_q    <= 1'b0;
            ctrl_q     <= 1'b0;
            caps_q     <= 1'b0;
            ev_valid_q <= 1'b0;
            ev_byte_q  <= 8'h00;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wdt_cnt_q  <= '0;
            wdt_pend_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            ctrl_q     <= ctrl_d;
            caps_q     <= caps_d;
            ev_valid_q <= ev_valid_d;
            ev_byte_q  <= ev_byte_d;
            wr_ptr_q   <= wr_ptr_q + AW'(push);
            rd_ptr_q   <= rd_ptr_q + AW'(pop);
            count_q    <= count_q + (AW + 1)'(push) - (AW + 1)'(pop);
            wdt_cnt_q  <= wdt_wrap ? '0 : wdt_cnt_q + WW'(1);
            // A wrap landing on the cycle a pending byte is pushed re-arms it.
            wdt_pend_q <= wdt_wrap ? 1'b1 : (wdt_push ? 1'b0 : wdt_pend_q);
            drop_q     <= ev_valid_q && !accept;
        end
    end

endmodule
